// File: rtl/spm_pkg.sv
// Shared types and sizing helpers for the serial-parallel multiplier.
package spm_pkg;

    // Controller states: waiting for operands, shifting the multiplier, holding the product.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } spm_state_t;

    // Legal operand widths.
    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 64;

    // Width of the cycle counter that spans the 2*width product bits.
    function automatic int cnt_w(input int width);
        return $clog2(2 * width);
    endfunction

endpackage

// File: rtl/spm_csa_cell.sv
// One bit slice of the carry-save array. The cell adds its partial-product bit
// (x_i & y_i), the sum arriving from the cell above (registered here) and its own
// registered carry. The sum output is combinational so that the bottom cell can
// deliver the product bit of the current cycle.
module spm_csa_cell (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic x_i,
    input  logic y_i,
    input  logic sin,
    output logic sc
);

    logic sin_q;
    logic carry_q;
    logic carry_d;
    logic and_t;

    // Full adder over partial product, delayed incoming sum and own carry.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
        and_t   = x_i & y_i;
        sc      = and_t ^ sin_q ^ carry_q;
        carry_d = (and_t & sin_q) | (and_t & carry_q) | (sin_q & carry_q);
    end

    // Sum-in and carry registers: cleared on operand accept, advanced only while running.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            sin_q   <= 1'b0;
            carry_q <= 1'b0;
        end else if (clr) begin
            sin_q   <= 1'b0;
            carry_q <= 1'b0;
        end else if (en) begin
            sin_q   <= sin;
            carry_q <= carry_d;
        end
    end

endmodule

// File: rtl/spm_seq_mult.sv
// Serial-parallel multiplier: x is held in parallel across WIDTH carry-save cells,
// y is shifted in LSB first and the 2*WIDTH-bit product is collected LSB first.
// Operands and result use valid/ready handshakes; a new operand pair may be
// accepted in the same cycle the previous product retires.
module spm_seq_mult
    import spm_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int SIGNED_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  logic                 signed_i,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PW - 1);

    spm_state_t        state_q;
    logic [WIDTH-1:0]  x_q;
    logic [PW-1:0]     y_sr_q;
    logic [PW-1:0]     y_sr_d;
    logic [PW-1:0]     p_sr_q;
    logic [PW-1:0]     p_sr_d;
    logic [PW-1:0]     p_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              sgn_q;
    logic              seen_q;
    logic              out_valid_q;
    logic              busy_q;

    logic              accept;
    logic              run;
    logic              ys;
    logic              eff_signed;
    logic [PW-1:0]     y_ext;
    logic              msb_term;
    logic              top_sin;
    logic              pbit;
    logic [WIDTH-1:0]  sc_w;
    logic [WIDTH-1:0]  sin_w;

    // Handshake, serial bit and operand extension.
    always_comb begin
        in_ready   = (state_q == IDLE) | ((state_q == DONE) & out_ready);
        accept     = in_valid & in_ready;
        run        = (state_q == RUN);
        ys         = y_sr_q[0];
        eff_signed = signed_i & (SIGNED_EN != 0);
        y_ext      = eff_signed ? {{WIDTH{y[WIDTH-1]}}, y} : {{WIDTH{1'b0}}, y};
        y_sr_d     = {1'b0, y_sr_q[PW-1:1]};
        p_sr_d     = {pbit, p_sr_q[PW-1:1]};
    end

    // Sign-weight correction for the top cell. In two's complement the MSB of x
    // carries weight -2^(WIDTH-1), but the top cell adds x[WIDTH-1]&ys with positive
    // weight. Feeding the serially negated stream of x[WIDTH-1]&ys into the top cell
    // (its sum input is delayed one cycle inside the cell, doubling its weight) adds
    // -2*term, so the net MSB contribution becomes -term as required. The negation
    // copies bits up to and including the first 1 and inverts every bit after it.
    always_comb begin
        msb_term = x_q[WIDTH-1] & ys;
        top_sin  = sgn_q & (msb_term ^ seen_q);
    end

    // Sum chain: each cell feeds the one below; cell 0 yields the product bit.
    assign sin_w = {top_sin, sc_w[WIDTH-1:1]};
    assign pbit  = sc_w[0];

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        spm_csa_cell u_cell (
            .clk (clk),
            .rst (rst),
            .clr (accept),
            .en  (run),
            .x_i (x_q[i]),
            .y_i (ys),
            .sin (sin_w[i]),
            .sc  (sc_w[i])
        );
    end

    // Controller: operand capture, serial shifting, product hand-off, registered flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_sr_q      <= '0;
            p_sr_q      <= '0;
            p_q         <= '0;
            cnt_q       <= '0;
            sgn_q       <= 1'b0;
            seen_q      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (accept) begin
            // Fresh operands, either from IDLE or back-to-back as a product retires.
            state_q     <= RUN;
            x_q         <= x;
            y_sr_q      <= y_ext;
            p_sr_q      <= '0;
            cnt_q       <= '0;
            sgn_q       <= eff_signed;
            seen_q      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    y_sr_q <= y_sr_d;
                    p_sr_q <= p_sr_d;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    seen_q <= seen_q | msb_term;
                    if (cnt_q == CNT_LAST) begin
                        state_q     <= DONE;
                        p_q         <= p_sr_d;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign p         = p_q;

endmodule
